// File: rtl/fifo_ctrl8_pkg.sv
// rtl/fifo_ctrl8_pkg.sv - shared depth constant and FSM state encodings for fifo_ctrl8
package fifo_ctrl8_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = 3;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_WR_RD  = 3'd4,
        ST_WR_ERR = 3'd5,
        ST_RD_ERR = 3'd6
    } state_t;

endpackage

// File: rtl/fifo_ctrl8_dec3to8.sv
// rtl/fifo_ctrl8_dec3to8.sv - 3-to-8 one-hot decoder with enable
module fifo_ctrl8_dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] dec
);

    assign dec = en ? (8'h01 << sel) : 8'h00;

endmodule

// File: rtl/fifo_ctrl8.sv
// rtl/fifo_ctrl8.sv - pointer/count controller for an 8-entry register-bank FIFO
module fifo_ctrl8
    import fifo_ctrl8_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [7:0]       reg_en,
    output logic [PTR_W-1:0] rd_sel,
    output logic [CNT_W-1:0] data_count,
    output logic             full,
    output logic             empty,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             rd_ack,
    output logic             rd_err,
    output logic [2:0]       state
);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    state_t           st;
    logic             push_ok;
    logic             pop_ok;
    logic             push_rej;
    logic             pop_rej;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push_ok    = wr_en & ~full;
    assign pop_ok     = rd_en & ~empty;
    assign push_rej   = wr_en & full;
    assign pop_rej    = rd_en & empty;
    assign rd_sel     = head;
    assign data_count = count;
    assign state      = st;

    // The bank captures on the same edge tail advances, so the enable is purely combinational.
    fifo_ctrl8_dec3to8 u_dec (
        .en  (push_ok),
        .sel (tail),
        .dec (reg_en)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            st     <= ST_INIT;
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
            rd_ack <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            if (push_ok) tail <= tail + 3'd1;
            if (pop_ok)  head <= head + 3'd1;

            case ({push_ok, pop_ok})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase

            wr_ack <= push_ok;
            wr_err <= push_rej;
            rd_ack <= pop_ok;
            rd_err <= pop_rej;

            // Accepted operations take priority over rejections for the reported state.
            if (push_ok && pop_ok)  st <= ST_WR_RD;
            else if (push_ok)       st <= ST_WRITE;
            else if (pop_ok)        st <= ST_READ;
            else if (push_rej)      st <= ST_WR_ERR;
            else if (pop_rej)       st <= ST_RD_ERR;
            else                    st <= ST_IDLE;
        end
    end

endmodule

// File: doc/fifo_ctrl8.md
FIFO_CTRL8 -- requirements
Module: fifo_ctrl8

Interface
REQ-001 Parameter: DEPTH, 8, number of entries in the controlled 8x32 enabled-register bank; fixed at 8, other values unsupported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 wr_en  input  1  push request, sampled each rising edge.
REQ-005 rd_en  input  1  pop request, sampled each rising edge.
REQ-006 reg_en  output  8  one-hot write enables to the register bank; combinational.
REQ-007 rd_sel  output  3  index of oldest entry (head) driving the bank output mux.
REQ-008 data_count  output  4  occupied entries, 0..8.
REQ-009 full / empty  output  1 each  data_count==8 / data_count==0; combinational from count.
REQ-010 wr_ack, wr_err, rd_ack, rd_err  output  1 each  registered result of the previous cycle's request.
REQ-011 state  output  3  current FSM state, for debug.

Function
REQ-012 Internal state: head[2:0], tail[2:0], count[3:0], 3-bit FSM state.
REQ-013 push_ok = wr_en & ~full; pop_ok = rd_en & ~empty; both evaluated from current-cycle registers.
REQ-014 reg_en SHALL be one-hot of tail when push_ok, else 8'h00; the bank captures data on the same edge the controller advances tail.
REQ-015 rd_sel SHALL equal head at all times; popped word is the one on the bank output during the pop cycle.
REQ-016 push_ok: tail <= tail+1 mod 8; pop_ok: head <= head+1 mod 8; pointers wrap 7->0 with no gap.
REQ-017 count: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither.
REQ-018 Simultaneous wr_en & rd_en when neither full nor empty: both performed, count unchanged.
REQ-019 Simultaneous when empty: push performed, pop rejected (rd_err).
REQ-020 Simultaneous when full: pop performed, push rejected (wr_err); no same-cycle write-through.
REQ-021 Push when full: no reg_en, tail/count unchanged, wr_err=1 next cycle.
REQ-022 Pop when empty: head/count unchanged, rd_err=1 next cycle.
REQ-023 FSM states: INIT, IDLE, WRITE, READ, WR_RD, WR_ERR, RD_ERR; next state from this cycle's request: none->IDLE, push_ok only->WRITE, pop_ok only->READ, both ok->WR_RD, rejected push (no pop)->WR_ERR, rejected pop (no push)->RD_ERR; for REQ-019/020 cases the state reflects the accepted operation (WRITE/READ) and the err flag reflects the rejection.
REQ-024 INIT exits to next-state logic on the first clock after reset release; requests in that first cycle are processed normally.
REQ-025 wr_ack/rd_ack/wr_err/rd_err SHALL be 1-cycle pulses, registered, asserted the cycle after the causing request.
REQ-026 data_count SHALL never exceed 8 nor underflow below 0.

Reset
REQ-027 reset_n low asynchronously forces head=0, tail=0, count=0, state=INIT, all ack/err=0.
REQ-028 Resulting outputs in reset: empty=1, full=0, data_count=0, rd_sel=0, reg_en=8'h00.
REQ-029 Reset mid-operation discards all entries; bank contents are not the controller's concern.

Structure
REQ-030 State encodings and DEPTH constant SHALL live in a shared defines header used by controller and bench.
REQ-031 One sub-module: _dec3to8 (3-to-8 one-hot decoder with enable) producing reg_en.
REQ-032 Top-level fifo wrapper instantiates fifo_ctrl8 plus the existing 8x32 register bank and an 8:1 32-bit mux on rd_sel.

Verification
REQ-033 Reset, then 8 pushes of 0x11..0x88 -> reg_en walks 01,02..80; data_count 8; full=1; 8 wr_ack pulses.
REQ-034 9th push while full -> reg_en=00, wr_err=1 for one cycle, state=WR_ERR, count stays 8.
REQ-035 8 pops -> rd_sel 0..7, data out 0x11..0x88 in order, empty=1; 9th pop -> rd_err=1, state=RD_ERR.
REQ-036 Wrap: push 5, pop 5, push 6 -> tail wraps 7->0->3, head=5, count=6, pops return data in order.
REQ-037 Simultaneous wr_en&rd_en at count 0, 4, 8 -> count 1 (rd_err), 4 (WR_RD), 7 (wr_err) respectively.
REQ-038 reset_n pulsed low mid-stream at count 5 -> immediate count 0, empty=1, state=INIT, no clock required.
